fetch_unit: RTL and testbench

Instruction fetch stage of the core. Sits directly upstream of the synchronous instruction memory: it owns the program counter, drives the memory read address, and pairs each one-cycle-late read result with its PC. It presents instructions to decode over a valid/ready handshake, replays the address on stall so the memory output stays stable, and redirects immediately on branch/jump.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction memory
// address and pairs each one-cycle-late read result with its PC for decode.
package fetch_unit_pkg;
    typedef struct packed {
        logic [31:0] bits;
    } instruction_s;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    input  logic                    redirect_i,
    input  logic [addr_width_p-1:0] redirect_pc_i,
    output logic [addr_width_p-1:0] imem_addr_o,
    input  instruction_s            imem_instr_i,
    output instruction_s            instr_o,
    output logic [addr_width_p-1:0] pc_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [31:0]             fetch_count_o
);

    typedef logic [addr_width_p-1:0] addr_t;

    addr_t       pc_r;
    addr_t       rsp_pc_r;
    logic        rsp_valid_r;
    logic [31:0] count_r;

    logic        valid;
    logic        stall;
    logic        accept;

    // A redirect squashes whatever read result is arriving this cycle.
    assign valid  = rsp_valid_r && !redirect_i;
    assign stall  = valid && !ready_i;
    assign accept = valid && ready_i;

    assign valid_o       = valid;
    assign pc_o          = rsp_pc_r;
    assign instr_o       = imem_instr_i;
    assign fetch_count_o = count_r;

    // Replaying rsp_pc_r on a stall keeps the memory output, and so instr_o, stable.
    always_comb begin
        if (redirect_i) begin
            imem_addr_o = redirect_pc_i;
        end else if (stall) begin
            imem_addr_o = rsp_pc_r;
        end else begin
            imem_addr_o = pc_r;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_r        <= '0;
            rsp_pc_r    <= '0;
            rsp_valid_r <= 1'b0;
        end else if (redirect_i) begin
            rsp_pc_r    <= redirect_pc_i;
            rsp_valid_r <= en_i;
            pc_r        <= redirect_pc_i + addr_t'(1);
        end else if (stall) begin
            pc_r        <= pc_r;
            rsp_pc_r    <= rsp_pc_r;
            rsp_valid_r <= rsp_valid_r;
        end else if (en_i) begin
            rsp_pc_r    <= pc_r;
            rsp_valid_r <= 1'b1;
            pc_r        <= pc_r + addr_t'(1);
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_r <= '0;
        end else if (accept) begin
            count_r <= count_r + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] imem_addr;
    instruction_s  imem_instr;
    instruction_s  instr;
    logic [AW-1:0] pc;
    logic          valid;
    logic          ready = 1'b1;
    logic [31:0]   fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.addr_width_p(AW)) dut (
        .clk           (clk),
        .reset_n_i     (reset_n),
        .en_i          (en),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_instr_i  (imem_instr),
        .instr_o       (instr),
        .pc_o          (pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .fetch_count_o (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic instruction_s mem_word(input logic [AW-1:0] a);
        instruction_s w;
        w.bits = 32'hC0DE_0000 ^ {22'd0, a} ^ ({22'd0, a} << 16);
        return w;
    endfunction

    // Synchronous instruction memory: data for last cycle's address.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model: the read in flight (if any), the next sequential
    // address, and the number of handed-over instructions.
    bit          m_have;
    int          m_pc;
    int          m_nxt;
    int unsigned m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_have <= 1'b0;
            m_pc   <= 0;
            m_nxt  <= 0;
            m_cnt  <= 0;
        end else begin
            if (m_have && !redirect && ready) m_cnt <= m_cnt + 1;
            if (redirect) begin
                m_pc   <= int'(redirect_pc);
                m_have <= en;
                m_nxt  <= (int'(redirect_pc) + 1) % DEPTH;
            end else if (m_have && !ready) begin
                // held instruction waits for decode
            end else if (en) begin
                m_pc   <= m_nxt;
                m_have <= 1'b1;
                m_nxt  <= (m_nxt + 1) % DEPTH;
            end else begin
                m_have <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            automatic bit exp_valid = m_have && !redirect;
            automatic int exp_addr  = redirect ? int'(redirect_pc)
                                    : (exp_valid && !ready) ? m_pc : m_nxt;
            chk("m_valid", {31'd0, valid}, {31'd0, exp_valid});
            chk("m_addr", {22'd0, imem_addr}, 32'(exp_addr));
            chk("m_count", fetch_count, m_cnt);
            if (exp_valid) begin
                chk("m_pc", {22'd0, pc}, 32'(m_pc));
                chk("m_instr", instr.bits, mem_word(AW'(m_pc)).bits);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_pc", {22'd0, pc}, 32'd0);
        chk("rst_addr", {22'd0, imem_addr}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        en = 1'b1;
        ready = 1'b1;

        // straight-line fetch, cycles 0..5
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("line_addr", {22'd0, imem_addr}, 32'(k));
            chk("line_valid", {31'd0, valid}, (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) chk("line_pc", {22'd0, pc}, 32'(k - 1));
            next_cycle();
        end

        // stall on pc 5 for three cycles
        ready = 1'b0;
        @(negedge clk);
        chk("line_count", fetch_count, 32'd5);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            chk("stall_pc", {22'd0, pc}, 32'd5);
            chk("stall_addr", {22'd0, imem_addr}, 32'd5);
            next_cycle();
        end
        ready = 1'b1;
        @(negedge clk);
        chk("stall_rel_pc", {22'd0, pc}, 32'd5);
        next_cycle();

        // redirect while pc 6 is valid
        redirect = 1'b1;
        redirect_pc = 10'h200;
        @(negedge clk);
        chk("redir_valid", {31'd0, valid}, 32'd0);
        chk("redir_addr", {22'd0, imem_addr}, 32'h200);
        chk("redir_count", fetch_count, 32'd6);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_pc0", {22'd0, pc}, 32'h200);
        next_cycle();

        // redirect during stall on 0x201
        ready = 1'b0;
        @(negedge clk);
        chk("redir_pc1", {22'd0, pc}, 32'h201);
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 10'h010;
        @(negedge clk);
        chk("rds_valid", {31'd0, valid}, 32'd0);
        chk("rds_addr", {22'd0, imem_addr}, 32'h10);
        next_cycle();
        redirect = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("rds_pc", {22'd0, pc}, 32'h10);
        chk("rds_count", fetch_count, 32'd7);
        next_cycle();

        // wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 10'h3FF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_pc0", {22'd0, pc}, 32'h3FF);
        next_cycle();

        // enable drop while pc 0 is stalled
        ready = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("wrap_pc1", {22'd0, pc}, 32'h0);
        chk("wrap_valid", {31'd0, valid}, 32'd1);
        next_cycle();
        ready = 1'b1;
        @(negedge clk);
        chk("endrop_valid", {31'd0, valid}, 32'd1);
        chk("endrop_pc", {22'd0, pc}, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("endrop_idle", {31'd0, valid}, 32'd0);
        chk("endrop_count", fetch_count, 32'd10);
        next_cycle();
        en = 1'b1;
        @(negedge clk);
        chk("enrise_addr", {22'd0, imem_addr}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("enrise_pc", {22'd0, pc}, 32'd1);
        chk("enrise_valid", {31'd0, valid}, 32'd1);

        // asynchronous reset in the middle of a cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_pc", {22'd0, pc}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_addr", {22'd0, imem_addr}, 32'd0);
        next_cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!reset_n) begin
                reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
            end
            en = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 10'h3FF : AW'($urandom_range(0, DEPTH - 1));
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
